// File: rtl/spike_mac_driver.sv
// spike_mac_driver: presynaptic front end for a spiking neuron.
// On each rising edge of the timestep strobe it snapshots the spike vector,
// then sums the signed weights of the spiking inputs serially, one input per
// cycle. The reduced result goes to mac_out with a one-cycle mac_valid.
//
// Optional build macro:
//   SPK_MAC_SAT_EN  defined   -> result clamps to the signed OUT_W range
//                   undefined -> result keeps the low OUT_W bits (wraps)
//
// Assumes OUT_W < W_WIDTH + clog2(N_IN) + 1, which the default sizes satisfy.
module spike_mac_driver #(
    parameter int N_IN    = 8,
    parameter int W_WIDTH = 8,
    parameter int OUT_W   = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      pulse,
    input  logic [N_IN-1:0]           spk_in,
    input  logic                      w_we,
    input  logic [$clog2(N_IN)-1:0]   w_addr,
    input  logic signed [W_WIDTH-1:0] w_data,
    output logic signed [OUT_W-1:0]   mac_out,
    output logic                      mac_valid,
    output logic                      busy,
    output logic                      overrun
);

    localparam int IDX_W = $clog2(N_IN);
    // Wide enough that N_IN full-scale weights can never overflow.
    localparam int ACC_W = W_WIDTH + IDX_W + 1;

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_IN - 1);
    localparam logic [IDX_W:0]   ADDR_LIMIT = (IDX_W + 1)'(N_IN);

    localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W - 1){1'b1}}};
    localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W - 1){1'b0}}};
    localparam logic signed [ACC_W-1:0] ACC_MAX = {{(ACC_W - OUT_W){1'b0}}, OUT_MAX};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {{(ACC_W - OUT_W){1'b1}}, OUT_MIN};

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DONE
    } state_t;

    state_t                    state_q, state_d;
    logic                      pulse_q, pulse_d;
    logic [N_IN-1:0]           snap_q, snap_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic signed [W_WIDTH-1:0] weight_q [N_IN];
    logic signed [W_WIDTH-1:0] weight_d [N_IN];
    logic signed [OUT_W-1:0]   mac_out_q, mac_out_d;
    logic                      mac_valid_q, mac_valid_d;
    logic                      busy_q, busy_d;
    logic                      overrun_q, overrun_d;

    logic                      rise;
    logic signed [ACC_W-1:0]   term;
    logic signed [ACC_W-1:0]   acc_sum;
    logic signed [OUT_W-1:0]   reduced;

    // Next-state logic: edge detect, weight writes, serial accumulation and result reduction.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path can infer a latch.
        state_d     = state_q;
        pulse_d     = pulse;
        snap_d      = snap_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        weight_d    = weight_q;
        mac_out_d   = mac_out_q;
        mac_valid_d = 1'b0;
        busy_d      = busy_q;
        overrun_d   = overrun_q;

        rise = pulse & ~pulse_q;

        // Reads below use weight_q, so a same-cycle write to the index being summed is not seen.
        if (w_we && ({1'b0, w_addr} < ADDR_LIMIT)) begin
            weight_d[w_addr] = w_data;
        end

        term    = snap_q[idx_q]
                ? {{(ACC_W - W_WIDTH){weight_q[idx_q][W_WIDTH-1]}}, weight_q[idx_q]}
                : '0;
        acc_sum = acc_q + term;

`ifdef SPK_MAC_SAT_EN
        if (acc_sum > ACC_MAX) begin
            reduced = OUT_MAX;
        end else if (acc_sum < ACC_MIN) begin
            reduced = OUT_MIN;
        end else begin
            reduced = acc_sum[OUT_W-1:0];
        end
`else
        reduced = acc_sum[OUT_W-1:0];
`endif

        case (state_q)
            S_IDLE: begin
                if (rise) begin
                    snap_d  = spk_in;
                    acc_d   = '0;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                // A new strobe mid-sum is dropped but remembered.
                if (rise) begin
                    overrun_d = 1'b1;
                end
                acc_d = acc_sum;
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    mac_out_d   = reduced;
                    mac_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (rise) begin
                    overrun_d = 1'b1;
                end
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the weight file is cleared on reset because neuron behaviour after reset depends on zero weights.
            state_q     <= S_IDLE;
            pulse_q     <= 1'b0;
            snap_q      <= '0;
            acc_q       <= '0;
            idx_q       <= '0;
            weight_q    <= '{default: '0};
            mac_out_q   <= '0;
            mac_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q     <= state_d;
            pulse_q     <= pulse_d;
            snap_q      <= snap_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            weight_q    <= weight_d;
            mac_out_q   <= mac_out_d;
            mac_valid_q <= mac_valid_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
        end
    end

    assign mac_out   = mac_out_q;
    assign mac_valid = mac_valid_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_spike_mac_driver.sv
// Self-checking bench for spike_mac_driver (N_IN=8, W_WIDTH=8, OUT_W=8).
// A timeline model (elapsed cycles since the accepted strobe, integer sum)
// predicts every output each cycle; directed cases pin literal values.
// Honours SPK_MAC_SAT_EN the same way as the design.
module tb_spike_mac_driver;

    localparam int N_IN = 8;

    logic       clk;
    logic       reset;
    logic       pulse;
    logic [7:0] spk_in;
    logic       w_we;
    logic [2:0] w_addr;
    logic [7:0] w_data;
    logic [7:0] mac_out;
    logic       mac_valid;
    logic       busy;
    logic       overrun;

    spike_mac_driver #(.N_IN(8), .W_WIDTH(8), .OUT_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .pulse     (pulse),
        .spk_in    (spk_in),
        .w_we      (w_we),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .mac_out   (mac_out),
        .mac_valid (mac_valid),
        .busy      (busy),
        .overrun   (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         m_w [N_IN];
    int         m_e;        // 0 = idle, 1..N_IN summing input e-1, N_IN+1 = result cycle
    int         m_sum;
    logic [7:0] m_snap;
    logic       m_p;
    int         exp_mac, exp_valid, exp_busy, exp_ovr;

    function automatic int reduce(input int s);
`ifdef SPK_MAC_SAT_EN
        if (s > 127) return 127;
        if (s < -128) return -128;
        return s;
`else
        int r;
        r = ((s % 256) + 256) % 256;
        if (r > 127) r -= 256;
        return r;
`endif
    endfunction

    task automatic model_reset();
        foreach (m_w[i]) m_w[i] = 0;
        m_e = 0; m_sum = 0; m_snap = '0; m_p = 1'b0;
        exp_mac = 0; exp_valid = 0; exp_busy = 0; exp_ovr = 0;
    endtask

    task automatic model_step(input logic p, input logic [7:0] spk, input logic we,
                              input logic [2:0] a, input logic [7:0] d);
        bit rise;
        bit start;
        rise  = p && !m_p;
        start = 1'b0;
        m_p   = p;
        // input e-1 is summed with the weight in force before this cycle's write
        if (m_e >= 1 && m_e <= N_IN && m_snap[m_e-1]) m_sum += m_w[m_e-1];
        if (we) m_w[a] = int'($signed(d));
        if (rise) begin
            if (m_e != 0) exp_ovr = 1;
            else start = 1'b1;
        end
        if (m_e == N_IN + 1) m_e = 0;
        else if (m_e > 0) m_e++;
        if (start) begin
            m_e = 1; m_snap = spk; m_sum = 0;
        end
        exp_valid = (m_e == N_IN + 1) ? 1 : 0;
        if (exp_valid == 1) exp_mac = reduce(m_sum);
        exp_busy = (m_e != 0) ? 1 : 0;
    endtask

    // ---------------- compare process ----------------
    int ccnt = 0;
    int valid_cnt = 0;
    int last_val = 0;
    int last_valid_cyc = 0;
    bit chk_en = 1'b0;

    always begin
        @(posedge clk);
        #1;
        ccnt++;
        if (chk_en) begin
            check("mac_out",   int'($signed(mac_out)), exp_mac);
            check("mac_valid", int'(mac_valid),        exp_valid);
            check("busy",      int'(busy),             exp_busy);
            check("overrun",   int'(overrun),          exp_ovr);
        end
        if (mac_valid === 1'b1) begin
            valid_cnt++;
            last_val       = int'($signed(mac_out));
            last_valid_cyc = ccnt;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input logic rst, input logic p, input logic [7:0] spk,
                        input logic we, input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        reset = rst; pulse = p; spk_in = spk; w_we = we; w_addr = a; w_data = d;
        if (!rst) model_reset();
        else model_step(p, spk, we, a, d);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b1, 1'b0, 8'($urandom), 1'b0, 3'd0, 8'd0);
    endtask

    task automatic wait_valid(input string name, input int base);
        for (int i = 0; i < 20; i++) begin
            if (valid_cnt > base) break;
            idle(1);
        end
        check(name, (valid_cnt > base) ? 1 : 0, 1);
    endtask

    task automatic write_all(input logic [7:0] v);
        for (int i = 0; i < N_IN; i++) step(1'b1, 1'b0, 8'd0, 1'b1, 3'(i), v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    int r;
    int base;

    initial begin
        reset = 1'b1; pulse = 1'b0; spk_in = '0; w_we = 1'b0; w_addr = '0; w_data = '0;
        model_reset();
        #2;
        reset = 1'b0;
        chk_en = 1'b1;
        step(1'b0, 1'b0, 8'd0, 1'b0, 3'd0, 8'd0);

        // 1: reset mid-run, then release
        step(1'b1, 1'b0, 8'd0, 1'b0, 3'd0, 8'd0);
        step(1'b1, 1'b1, 8'hFF, 1'b0, 3'd0, 8'd0);
        idle(3);
        step(1'b0, 1'b0, 8'd0, 1'b0, 3'd0, 8'd0);
        step(1'b1, 1'b0, 8'd0, 1'b0, 3'd0, 8'd0);
        idle(1);
        check("t1_mac_out",   int'($signed(mac_out)), 0);
        check("t1_mac_valid", int'(mac_valid), 0);
        check("t1_busy",      int'(busy), 0);
        check("t1_overrun",   int'(overrun), 0);

        // 2: w0=3 w1=1 w2=5, spikes on 0 and 2
        step(1'b1, 1'b0, 8'd0, 1'b1, 3'd0, 8'd3);
        step(1'b1, 1'b0, 8'd0, 1'b1, 3'd1, 8'd1);
        step(1'b1, 1'b0, 8'd0, 1'b1, 3'd2, 8'd5);
        base = valid_cnt;
        step(1'b1, 1'b1, 8'b0000_0101, 1'b0, 3'd0, 8'd0);
        r = ccnt;
        wait_valid("t2_valid_seen", base);
        check("t2_value",   last_val, 8);
        check("t2_latency", last_valid_cyc - r, 9);

        // 3: all weights 100, all spikes
        write_all(8'd100);
        base = valid_cnt;
        step(1'b1, 1'b1, 8'hFF, 1'b0, 3'd0, 8'd0);
        wait_valid("t3_valid_seen", base);
`ifdef SPK_MAC_SAT_EN
        check("t3_value", last_val, 127);
`else
        check("t3_value", last_val, 32);
`endif

        // 4: all weights -128, all spikes
        write_all(8'h80);
        base = valid_cnt;
        step(1'b1, 1'b1, 8'hFF, 1'b0, 3'd0, 8'd0);
        wait_valid("t4_valid_seen", base);
`ifdef SPK_MAC_SAT_EN
        check("t4_value", last_val, -128);
`else
        check("t4_value", last_val, 0);
`endif

        // 5: second strobe 3 cycles after the first
        for (int i = 0; i < N_IN; i++) step(1'b1, 1'b0, 8'd0, 1'b1, 3'(i), 8'(i + 1));
        base = valid_cnt;
        step(1'b1, 1'b1, 8'h03, 1'b0, 3'd0, 8'd0);
        idle(2);
        step(1'b1, 1'b1, 8'hFF, 1'b0, 3'd0, 8'd0);
        wait_valid("t5_valid_seen", base);
        idle(12);
        check("t5_valid_count", valid_cnt - base, 1);
        check("t5_value",       last_val, 3);
        check("t5_overrun",     int'(overrun), 1);

        // 6: reset during accumulation, then an empty timestep
        base = valid_cnt;
        step(1'b1, 1'b1, 8'hFF, 1'b0, 3'd0, 8'd0);
        idle(3);
        step(1'b0, 1'b0, 8'd0, 1'b0, 3'd0, 8'd0);
        step(1'b0, 1'b0, 8'd0, 1'b0, 3'd0, 8'd0);
        check("t6_no_valid", valid_cnt - base, 0);
        check("t6_mac_out",  int'($signed(mac_out)), 0);
        check("t6_busy",     int'(busy), 0);
        check("t6_overrun",  int'(overrun), 0);
        step(1'b1, 1'b0, 8'd0, 1'b0, 3'd0, 8'd0);
        step(1'b1, 1'b1, 8'h00, 1'b0, 3'd0, 8'd0);
        r = ccnt;
        wait_valid("t6_valid_seen", base);
        check("t6_value",   last_val, 0);
        check("t6_latency", last_valid_cyc - r, 9);

        // random traffic: strobes, weight writes at any time, rare resets
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 249) == 0) ? 1'b0 : 1'b1,
                 ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0,
                 8'($urandom),
                 ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0,
                 3'($urandom),
                 8'($urandom));
        end
        idle(15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
